// File: rtl/sw_debounce_pkg.sv
// Shared types and cycle-count helper for the push-switch debouncer.
// Pure declarations: no logic, no latency, no flow control.
package sw_debounce_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } sw_db_state_e;

  // Truncating divide first keeps 27 MHz * 1000 ms inside a 32-bit int.
  function automatic int ms_to_cyc(input int clk_hz, input int ms);
    return (clk_hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/sw_debounce_if.sv
// Switch bundle between the board pins and the debouncer; master drives raw switches.
// Outputs are registered levels and single-cycle pulses; no backpressure exists.
interface sw_debounce_if #(
  parameter int N_SW = 2
);

  logic [N_SW-1:0] sw_n;
  logic [N_SW-1:0] sw_level;
  logic [N_SW-1:0] sw_press;
  logic [N_SW-1:0] sw_release;
  logic [N_SW-1:0] sw_long;

  modport master (
    output sw_n,
    input  sw_level,
    input  sw_press,
    input  sw_release,
    input  sw_long
  );

  modport slave (
    input  sw_n,
    output sw_level,
    output sw_press,
    output sw_release,
    output sw_long
  );

endinterface

// File: rtl/sw_debounce_ch.sv
// One switch channel: 2-FF sync, debounce FSM, optional hold counter (SW_LONGPRESS_EN).
// Level/press change 2+DB_CYC edges after a stable input change; free-running, no backpressure.
module sw_debounce_ch
  import sw_debounce_pkg::*;
#(
  parameter int DB_CYC = 4
`ifdef SW_LONGPRESS_EN
  , parameter int LONG_CYC = 20
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_n,
  output logic level,
  output logic press_p,
  output logic release_p,
  output logic long_p
);

  localparam int              DB_W    = $clog2(DB_CYC + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYC - 1);

  logic [1:0]      sync_q;
  logic            sync_on;
  sw_db_state_e    state_q;
  sw_db_state_e    state_d;
  logic [DB_W-1:0] cnt_q;
  logic [DB_W-1:0] cnt_d;
  logic            press_q;
  logic            press_d;
  logic            release_q;
  logic            release_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= 2'b00;
      state_q   <= RELEASED;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], ~sw_n};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign sync_on = sync_q[1];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      RELEASED: begin
        cnt_d = '0;
        if (sync_on) begin
          state_d = PRESS_WAIT;
        end
      end
      PRESS_WAIT: begin
        if (!sync_on) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        cnt_d = '0;
        if (!sync_on) begin
          state_d = RELEASE_WAIT;
        end
      end
      RELEASE_WAIT: begin
        // A bounce back to pressed is not an event; level never dropped.
        if (sync_on) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d   = RELEASED;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  assign level     = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
  assign press_p   = press_q;
  assign release_p = release_q;

`ifdef SW_LONGPRESS_EN
  localparam int                HOLD_W    = $clog2(LONG_CYC + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LONG_CYC);

  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] hold_d;
  logic              long_q;
  logic              long_d;

  // Parking at LONG_CYC keeps the pulse to one per hold.
  always_comb begin
    hold_d = '0;
    long_d = 1'b0;
    if (state_q == PRESSED) begin
      long_d = (hold_q == HOLD_LAST);
      hold_d = (hold_q == HOLD_SAT) ? hold_q : hold_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign long_p = long_q;
`else
  assign long_p = 1'b0;
`endif

endmodule

// File: rtl/sw_debounce.sv
// N_SW-channel push-switch debouncer; SW_LONGPRESS_EN adds the long-press pulse.
// Events land 2+DB_CYC edges after a stable input change; no backpressure.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int N_SW        = 2,
  parameter int CLK_HZ      = 27_000_000,
  parameter int DEBOUNCE_MS = 10,
  parameter int LONG_MS     = 1000
) (
  input  logic          clk,
  input  logic          rst,
  sw_debounce_if.slave  sw
);

  localparam int DB_CYC   = ms_to_cyc(CLK_HZ, DEBOUNCE_MS);
  localparam int LONG_CYC = ms_to_cyc(CLK_HZ, LONG_MS);

  if (DB_CYC < 1 || LONG_CYC < 1) begin : g_cfg_err
    $error("sw_debounce: debounce and long-press times must be at least one clock");
  end

  for (genvar i = 0; i < N_SW; i++) begin : g_ch
    sw_debounce_ch #(
      .DB_CYC   (DB_CYC)
`ifdef SW_LONGPRESS_EN
      , .LONG_CYC (LONG_CYC)
`endif
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .sw_n      (sw.sw_n[i]),
      .level     (sw.sw_level[i]),
      .press_p   (sw.sw_press[i]),
      .release_p (sw.sw_release[i]),
      .long_p    (sw.sw_long[i])
    );
  end

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce: history-window model checked every cycle plus directed timing pins.
// CLK_HZ=1000, DEBOUNCE_MS=4, LONG_MS=20 give DB_CYC=4 and LONG_CYC=20.
module tb_sw_debounce;

  localparam int N_SW   = 2;
  localparam int DB_CYC = 4;
`ifdef SW_LONGPRESS_EN
  localparam int LONG_CYC = 20;
`endif

  logic clk = 1'b0;
  logic rst;

  sw_debounce_if #(.N_SW(N_SW)) sw_if ();

  sw_debounce #(
    .N_SW        (N_SW),
    .CLK_HZ      (1000),
    .DEBOUNCE_MS (4),
    .LONG_MS     (20)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sw  (sw_if)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  // Model state: a pressed/released change is accepted once the last DB_CYC+1
  // synchronised samples all disagree with the current debounced level.
  bit              d1 [N_SW];
  bit              d2 [N_SW];
  bit              last_s [N_SW];
  bit              hist [N_SW][$];
  logic [N_SW-1:0] m_level = '0;
  logic [N_SW-1:0] m_press = '0;
  logic [N_SW-1:0] m_rel   = '0;
  logic [N_SW-1:0] m_long  = '0;
`ifdef SW_LONGPRESS_EN
  int              run [N_SW];
`endif

  always @(posedge clk) begin
    cyc++;
    for (int c = 0; c < N_SW; c++) begin
      if (rst) begin
        d1[c]      = 1'b0;
        d2[c]      = 1'b0;
        last_s[c]  = 1'b0;
        hist[c].delete();
        m_level[c] = 1'b0;
        m_press[c] = 1'b0;
        m_rel[c]   = 1'b0;
        m_long[c]  = 1'b0;
`ifdef SW_LONGPRESS_EN
        run[c]     = 0;
`endif
      end else begin
        bit s;
        bit flip;
`ifdef SW_LONGPRESS_EN
        bit in_hold;
        in_hold = m_level[c] && last_s[c];
`endif
        s         = d2[c];
        d2[c]     = d1[c];
        d1[c]     = ~sw_if.sw_n[c];
        last_s[c] = s;
        hist[c].push_back(s);
        if (hist[c].size() > DB_CYC + 1) void'(hist[c].pop_front());
        flip = (hist[c].size() == DB_CYC + 1);
        for (int k = 0; k < hist[c].size(); k++) begin
          if (hist[c][k] == m_level[c]) flip = 1'b0;
        end
        m_press[c] = flip && !m_level[c];
        m_rel[c]   = flip && m_level[c];
        if (flip) begin
          m_level[c] = !m_level[c];
          hist[c].delete();
        end
        m_long[c] = 1'b0;
`ifdef SW_LONGPRESS_EN
        if (in_hold) begin
          run[c]++;
          m_long[c] = (run[c] == LONG_CYC);
        end else begin
          run[c] = 0;
        end
`endif
      end
    end
    chk_en = 1'b1;
  end

  int press_cnt [N_SW];
  int rel_cnt   [N_SW];
  int long_cnt  [N_SW];
  int press_cyc [N_SW];
  int rel_cyc   [N_SW];
  int long_cyc  [N_SW];
  int both_cyc  = -1;

  always @(negedge clk) begin
    if (chk_en) begin
      n_chk++;
      if ({sw_if.sw_level, sw_if.sw_press, sw_if.sw_release, sw_if.sw_long} !==
          {m_level, m_press, m_rel, m_long}) begin
        n_fail++;
        $display("FAIL model_cycle @%0d: dut lvl/prs/rel/long=%b/%b/%b/%b model=%b/%b/%b/%b",
                 cyc, sw_if.sw_level, sw_if.sw_press, sw_if.sw_release, sw_if.sw_long,
                 m_level, m_press, m_rel, m_long);
      end
      for (int c = 0; c < N_SW; c++) begin
        if (sw_if.sw_press[c] === 1'b1)   begin press_cnt[c]++; press_cyc[c] = cyc; end
        if (sw_if.sw_release[c] === 1'b1) begin rel_cnt[c]++;   rel_cyc[c]   = cyc; end
        if (sw_if.sw_long[c] === 1'b1)    begin long_cnt[c]++;  long_cyc[c]  = cyc; end
      end
      if (sw_if.sw_press === 2'b11) both_cyc = cyc;
    end
  end

  task automatic check(input string name, input int act, input int expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  int t;

  initial begin
    rst = 1'b1;
    sw_if.sw_n = '1;
    for (int c = 0; c < N_SW; c++) begin
      press_cnt[c] = 0; rel_cnt[c] = 0; long_cnt[c] = 0;
      press_cyc[c] = -1; rel_cyc[c] = -1; long_cyc[c] = -1;
    end
    tick(3);
    check("reset_level",   int'(sw_if.sw_level),   0);
    check("reset_press",   int'(sw_if.sw_press),   0);
    check("reset_release", int'(sw_if.sw_release), 0);
    check("reset_long",    int'(sw_if.sw_long),    0);
    rst = 1'b0;
    tick(2);

    // Clean press on ch0: pulse on edge t+6.
    sw_if.sw_n[0] = 1'b0; t = cyc + 1; tick(10);
    check("clean_press_edge", press_cyc[0], t + 6);
    check("clean_press_cnt",  press_cnt[0], 1);
    check("clean_level0",     int'(sw_if.sw_level[0]), 1);
    check("clean_ch1_quiet",  press_cnt[1] + int'(sw_if.sw_level[1]), 0);

    // Clean release.
    sw_if.sw_n[0] = 1'b1; t = cyc + 1; tick(10);
    check("release_edge",  rel_cyc[0], t + 6);
    check("release_cnt",   rel_cnt[0], 1);
    check("release_level", int'(sw_if.sw_level[0]), 0);

    // Glitch shorter than the debounce window.
    sw_if.sw_n[0] = 1'b0; tick(3); sw_if.sw_n[0] = 1'b1; tick(10);
    check("glitch_no_press", press_cnt[0], 1);

    // Bounce: low 3, high 1, then low held.
    sw_if.sw_n[0] = 1'b0; tick(3); sw_if.sw_n[0] = 1'b1; tick(1);
    sw_if.sw_n[0] = 1'b0; t = cyc + 1; tick(10);
    check("bounce_press_edge", press_cyc[0], t + 6);
    check("bounce_press_cnt",  press_cnt[0], 2);
    sw_if.sw_n[0] = 1'b1; tick(10);
    check("bounce_release_cnt", rel_cnt[0], 2);

    // Shortest accepted press: low for exactly DB_CYC+1 cycles.
    sw_if.sw_n[0] = 1'b0; t = cyc + 1; tick(5); sw_if.sw_n[0] = 1'b1; tick(10);
    check("min_press_edge",   press_cyc[0], t + 6);
    check("min_release_edge", rel_cyc[0],   t + 11);
    check("min_press_cnt",    press_cnt[0], 3);

    // Simultaneous press on both channels.
    sw_if.sw_n = 2'b00; t = cyc + 1; tick(10);
    check("simul_press0", press_cyc[0], t + 6);
    check("simul_press1", press_cyc[1], t + 6);
    check("simul_both",   both_cyc,     t + 6);
    sw_if.sw_n = 2'b11; tick(10);
    check("simul_release1", rel_cnt[1], 1);

    // Hold 30 cycles, then hold 15 cycles.
    sw_if.sw_n[0] = 1'b0; t = cyc + 1; tick(30); sw_if.sw_n[0] = 1'b1; tick(10);
    check("hold30_press_edge", press_cyc[0], t + 6);
`ifdef SW_LONGPRESS_EN
    check("hold30_long_edge", long_cyc[0], t + 26);
    check("hold30_long_cnt",  long_cnt[0], 1);
`else
    check("hold30_long_cnt",  long_cnt[0], 0);
`endif
    sw_if.sw_n[0] = 1'b0; tick(15); sw_if.sw_n[0] = 1'b1; tick(10);
    check("hold15_press_cnt", press_cnt[0], 6);
`ifdef SW_LONGPRESS_EN
    check("hold15_long_cnt", long_cnt[0], 1);
`else
    check("hold15_long_cnt", long_cnt[0], 0);
`endif

    // Reset one cycle at edge t+3 of a press: progress discarded, re-accepted.
    sw_if.sw_n[0] = 1'b0; t = cyc + 1; tick(3);
    rst = 1'b1; tick(1); rst = 1'b0; tick(12);
    check("rst_mid_press_edge", press_cyc[0], t + 10);
    check("rst_mid_press_cnt",  press_cnt[0], 7);
    sw_if.sw_n[0] = 1'b1; tick(10);
    check("final_release_cnt", rel_cnt[0], 7);
    check("final_long_ch1",    long_cnt[1], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
